// File: rtl/axil_snn_slave_if.sv
// AXI4-Lite channel bundle between a host master and the SNN accelerator register slave.
interface axil_snn_slave_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_snn_slave.sv
// AXI4-Lite register/image-buffer slave for the SNN accelerator core: control, status, result
// and a pixel buffer shared with the core through a registered read port.
module axil_snn_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned PIXEL_BITS     = 8,
  parameter int unsigned IMAGE_SIZE     = 256,
  localparam int unsigned PIX_AW        = $clog2(IMAGE_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  axil_snn_slave_if.slave       axi,
  output logic                  start_o,
  input  logic [PIX_AW-1:0]     pix_addr_i,
  output logic [PIXEL_BITS-1:0] pix_data_o,
  input  logic                  core_done_i,
  input  logic [7:0]            core_label_i
);

  localparam int unsigned LO_W = (PIXEL_BITS > 2) ? PIXEL_BITS : 2;
  localparam logic [9:0]  WO_CTRL = 10'd0;
  localparam logic [9:0]  WO_STAT = 10'd1;
  localparam logic [9:0]  WO_RSLT = 10'd2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [8:0]  IMG_LIM = 9'(IMAGE_SIZE);

  // Pixel window starts at byte 0x400, one word per pixel.
  function automatic logic pix_hit(input logic [11:0] off);
    return (off[11:10] == 2'b01) && ({1'b0, off[9:2]} < IMG_LIM);
  endfunction

  logic [PIXEL_BITS-1:0]     buf_q [IMAGE_SIZE];

  logic                      aw_vld_q, aw_vld_d;
  logic [11:0]               aw_off_q, aw_off_d;
  logic                      w_vld_q, w_vld_d;
  logic [LO_W-1:0]           w_lo_q, w_lo_d;
  logic                      w_strb0_q, w_strb0_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      start_q, start_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [7:0]                rslt_q, rslt_d;
  logic [PIXEL_BITS-1:0]     pix_data_q, pix_data_d;
  logic                      mem_we_c;
  logic [PIX_AW-1:0]         mem_idx_c;
  logic [11:0]               ar_off_c;
  logic [PIX_AW-1:0]         ar_idx_c;
  logic                      unused_c;

  assign unused_c = ^{axi.awaddr[AXI_ADDR_WIDTH-1:12], axi.awprot, axi.araddr[AXI_ADDR_WIDTH-1:12],
                      axi.araddr[1:0], axi.arprot, axi.wdata[AXI_DATA_WIDTH-1:LO_W], axi.wstrb[3:1]};
  assign ar_off_c = axi.araddr[11:0];
  assign ar_idx_c = ar_off_c[PIX_AW+1:2];

  always_comb begin
    aw_vld_d   = aw_vld_q;
    aw_off_d   = aw_off_q;
    w_vld_d    = w_vld_q;
    w_lo_d     = w_lo_q;
    w_strb0_d  = w_strb0_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    start_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = done_q;
    rslt_d     = rslt_q;
    mem_we_c   = 1'b0;
    mem_idx_c  = aw_off_q[PIX_AW+1:2];

    // Address and data channels latch independently.
    if (axi.awvalid && awready_q) begin
      aw_vld_d = 1'b1;
      aw_off_d = axi.awaddr[11:0];
    end
    if (axi.wvalid && wready_q) begin
      w_vld_d   = 1'b1;
      w_lo_d    = axi.wdata[LO_W-1:0];
      w_strb0_d = axi.wstrb[0];
    end
    if (bvalid_q && axi.bready) bvalid_d = 1'b0;

    if (aw_vld_q && w_vld_q) begin
      aw_vld_d = 1'b0;
      w_vld_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      if (aw_off_q[11:2] == WO_CTRL) begin
        if (w_strb0_q) begin
          if (w_lo_q[0]) begin
            if (busy_q) begin
              bresp_d = RESP_SLVERR;
            end else begin
              start_d = 1'b1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end
          end
          if (w_lo_q[1]) done_d = 1'b0;
        end
      end else if (pix_hit(aw_off_q)) begin
        if (w_strb0_q) begin
          if (busy_q) bresp_d = RESP_SLVERR;
          else        mem_we_c = 1'b1;
        end
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end

    // Evaluated after the CTRL write so a coincident CORE_DONE leaves DONE set.
    if (core_done_i && busy_q) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      rslt_d = core_label_i;
    end

    if (rvalid_q && axi.rready) rvalid_d = 1'b0;
    if (axi.arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      if (ar_off_c[11:2] == WO_STAT)      rdata_d = AXI_DATA_WIDTH'({done_q, busy_q});
      else if (ar_off_c[11:2] == WO_RSLT) rdata_d = AXI_DATA_WIDTH'(rslt_q);
      else if (pix_hit(ar_off_c))         rdata_d = AXI_DATA_WIDTH'(buf_q[ar_idx_c]);
      else if (ar_off_c[11:2] != WO_CTRL) rresp_d = RESP_SLVERR;
    end

    awready_d  = !aw_vld_d && !bvalid_d;
    wready_d   = !w_vld_d && !bvalid_d;
    arready_d  = !rvalid_d;
    pix_data_d = buf_q[pix_addr_i];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_vld_q   <= 1'b0;
      aw_off_q   <= '0;
      w_vld_q    <= 1'b0;
      w_lo_q     <= '0;
      w_strb0_q  <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rslt_q     <= '0;
      pix_data_q <= '0;
    end else begin
      aw_vld_q   <= aw_vld_d;
      aw_off_q   <= aw_off_d;
      w_vld_q    <= w_vld_d;
      w_lo_q     <= w_lo_d;
      w_strb0_q  <= w_strb0_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rslt_q     <= rslt_d;
      pix_data_q <= pix_data_d;
    end
  end

  // Image buffer keeps its contents across reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) buf_q[mem_idx_c] <= w_lo_q[PIXEL_BITS-1:0];
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
  assign start_o     = start_q;
  assign pix_data_o  = pix_data_q;

endmodule
